// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine bridging the pipeline to a
// single-outstanding request/acknowledge memory bus.
//
// Ports
//   clk, reset             clock and asynchronous active-low reset
//   MemReadM, MemWriteM    load / store present in the MEM stage
//   MemOpM[2:0]            access size and signedness (unknown codes = word)
//   ALUOutM[31:0]          effective byte address
//   WriteDataM[31:0]       right-aligned store data
//   ReadDataM[31:0]        extended load data (registered)
//   StallM                 pipeline freeze request (combinational)
//   AdELM, AdESM           misaligned load / store (combinational)
//   mem_req, mem_we        bus request and write strobe (registered)
//   mem_addr, mem_be       word-aligned address and byte enables (registered)
//   mem_wdata              lane-replicated store data (registered)
//   mem_rdata, mem_ack     bus read data and single-cycle completion
//   BusErrM                access timed out (only with MEM_TIMEOUT_EN)
//
// Build option: define MEM_TIMEOUT_EN to abort an access after 255 REQ cycles
// without mem_ack; the abort returns 32'hDEADBEEF and pulses BusErrM.
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  MemOpM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        AdELM,
   output logic        AdESM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
`ifdef MEM_TIMEOUT_EN
   ,
   output logic        BusErrM
`endif
);

   localparam int unsigned DW  = 32;
   localparam int unsigned BEW = 4;
   localparam int unsigned OPW = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state,     w_state_nxt;
   logic             r_mem_req,   w_mem_req_nxt;
   logic             r_mem_we,    w_mem_we_nxt;
   logic [DW-1:0]    r_mem_addr,  w_mem_addr_nxt;
   logic [BEW-1:0]   r_mem_be,    w_mem_be_nxt;
   logic [DW-1:0]    r_mem_wdata, w_mem_wdata_nxt;
   logic [DW-1:0]    r_rdata,     w_rdata_nxt;
   logic [OPW-1:0]   r_op,        w_op_nxt;
   logic [1:0]       r_off,       w_off_nxt;
   logic             r_is_load,   w_is_load_nxt;
   logic             w_stall;
   logic             w_adel;
   logic             w_ades;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(254);
   logic [CW-1:0]    r_cnt,       w_cnt_nxt;
   logic             r_bus_err,   w_bus_err_nxt;
`endif

   // Access-size decode from the incoming MEM-stage op
   logic w_is_half;
   logic w_is_byte;
   logic w_is_word;
   logic w_load;
   logic w_store;
   logic w_misalign;

   assign w_is_half  = (MemOpM == 3'b001) || (MemOpM == 3'b010);
   assign w_is_byte  = (MemOpM == 3'b011) || (MemOpM == 3'b100);
   assign w_is_word  = !(w_is_half || w_is_byte);
   assign w_load     = MemReadM;
   assign w_store    = MemWriteM && !MemReadM;
   assign w_misalign = (w_is_word && (ALUOutM[1:0] != 2'b00)) ||
                       (w_is_half && ALUOutM[0]);

   // Lane select and sign/zero extension of returned read data
   function automatic logic [DW-1:0] f_extend(input logic [OPW-1:0] op,
                                               input logic [1:0]     off,
                                               input logic [DW-1:0]  d);
      logic [15:0] h;
      logic [7:0]  b;
      h = off[1] ? d[31:16] : d[15:0];
      b = d[{off, 3'b000} +: 8];
      case (op)
         3'b001:  f_extend = {{16{h[15]}}, h};
         3'b010:  f_extend = {16'h0000, h};
         3'b011:  f_extend = {{24{b[7]}}, b};
         3'b100:  f_extend = {24'h000000, b};
         default: f_extend = d;
      endcase
   endfunction

   // Byte enables for the store lanes
   function automatic logic [BEW-1:0] f_be(input logic is_half,
                                           input logic is_byte,
                                           input logic [1:0] off);
      if (is_byte)      f_be = BEW'(4'b0001 << off);
      else if (is_half) f_be = off[1] ? 4'b1100 : 4'b0011;
      else              f_be = 4'b1111;
   endfunction

   // Store data replicated across every lane it may land in
   function automatic logic [DW-1:0] f_wdata(input logic is_half,
                                             input logic is_byte,
                                             input logic [DW-1:0] d);
      if (is_byte)      f_wdata = {4{d[7:0]}};
      else if (is_half) f_wdata = {2{d[15:0]}};
      else              f_wdata = d;
   endfunction

   // Next-state and combinational outputs
   always_comb begin
      w_state_nxt     = r_state;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_be_nxt    = r_mem_be;
      w_mem_wdata_nxt = r_mem_wdata;
      w_rdata_nxt     = r_rdata;
      w_op_nxt        = r_op;
      w_off_nxt       = r_off;
      w_is_load_nxt   = r_is_load;
      w_stall         = 1'b0;
      w_adel          = 1'b0;
      w_ades          = 1'b0;
`ifdef MEM_TIMEOUT_EN
      w_cnt_nxt       = r_cnt;
      w_bus_err_nxt   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_load || w_store) begin
               if (w_misalign) begin
                  w_adel = w_load;
                  w_ades = w_store;
               end else begin
                  w_stall         = 1'b1;
                  w_state_nxt     = S_REQ;
                  w_mem_req_nxt   = 1'b1;
                  w_mem_we_nxt    = w_store;
                  w_mem_addr_nxt  = {ALUOutM[31:2], 2'b00};
                  w_mem_be_nxt    = f_be(w_is_half, w_is_byte, ALUOutM[1:0]);
                  w_mem_wdata_nxt = f_wdata(w_is_half, w_is_byte, WriteDataM);
                  w_op_nxt        = MemOpM;
                  w_off_nxt       = ALUOutM[1:0];
                  w_is_load_nxt   = w_load;
`ifdef MEM_TIMEOUT_EN
                  w_cnt_nxt       = '0;
`endif
               end
            end
         end
         S_REQ: begin
            w_stall = 1'b1;
            if (mem_ack) begin
               w_state_nxt   = S_DONE;
               w_mem_req_nxt = 1'b0;
               w_mem_we_nxt  = 1'b0;
               if (r_is_load) w_rdata_nxt = f_extend(r_op, r_off, mem_rdata);
            end
`ifdef MEM_TIMEOUT_EN
            else if (r_cnt == TIMEOUT_LAST) begin
               // 255th REQ cycle without ack: give up on the access
               w_state_nxt   = S_DONE;
               w_mem_req_nxt = 1'b0;
               w_mem_we_nxt  = 1'b0;
               w_rdata_nxt   = 32'hDEADBEEF;
               w_bus_err_nxt = 1'b1;
               w_cnt_nxt     = r_cnt + CW'(1);
            end else begin
               w_cnt_nxt     = r_cnt + CW'(1);
            end
`endif
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_op        <= '0;
         r_off       <= '0;
         r_is_load   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_cnt       <= '0;
         r_bus_err   <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_be    <= w_mem_be_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_rdata     <= w_rdata_nxt;
         r_op        <= w_op_nxt;
         r_off       <= w_off_nxt;
         r_is_load   <= w_is_load_nxt;
`ifdef MEM_TIMEOUT_EN
         r_cnt       <= w_cnt_nxt;
         r_bus_err   <= w_bus_err_nxt;
`endif
      end
   end

   // Combinational flags are masked while reset is held
   assign StallM    = reset && w_stall;
   assign AdELM     = reset && w_adel;
   assign AdESM     = reset && w_ades;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign ReadDataM = r_rdata;
`ifdef MEM_TIMEOUT_EN
   assign BusErrM   = r_bus_err;
`endif

endmodule
